// File: rtl/fbuf_fill_arbiter_if.sv
// Framebuffer write-port bundle shared by the GPU, the fill engine and the BRAM.
// master: drives the GPU request and fill command, observes the BRAM write port
//         and status flags (testbench / surrounding system side).
// slave : the arbiter itself.
// Signals:
//   gpu_wr_valid/ready/addr/data  GPU pixel write handshake
//   fill_start/base/len/color     fill command (fill_len == 0 is a no-op)
//   fill_busy, fill_done          fill status
//   fbuf_en_wr, fbuf_wrea,
//   fbuf_addr, fbuf_data          registered BRAM write port
interface fbuf_fill_arbiter_if #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8
);
    logic                       gpu_wr_valid;
    logic                       gpu_wr_ready;
    logic [FBUF_ADDR_WIDTH-1:0] gpu_wr_addr;
    logic [FBUF_DATA_WIDTH-1:0] gpu_wr_data;

    logic                       fill_start;
    logic [FBUF_ADDR_WIDTH-1:0] fill_base;
    logic [FBUF_ADDR_WIDTH-1:0] fill_len;
    logic [FBUF_DATA_WIDTH-1:0] fill_color;
    logic                       fill_busy;
    logic                       fill_done;

    logic                       fbuf_en_wr;
    logic                       fbuf_wrea;
    logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
    logic [FBUF_DATA_WIDTH-1:0] fbuf_data;

    modport master (
        output gpu_wr_valid, gpu_wr_addr, gpu_wr_data,
        output fill_start, fill_base, fill_len, fill_color,
        input  gpu_wr_ready, fill_busy, fill_done,
        input  fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );

    modport slave (
        input  gpu_wr_valid, gpu_wr_addr, gpu_wr_data,
        input  fill_start, fill_base, fill_len, fill_color,
        output gpu_wr_ready, fill_busy, fill_done,
        output fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );
endinterface

// File: rtl/fbuf_fill_arbiter.sv
// Shares one framebuffer BRAM write port between GPU pixel writes and a
// rectangular-run fill engine. Round-robin between the two while a fill is
// running; the GPU owns the port otherwise. BRAM outputs are registered.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fbuf_fill_arbiter_if slave modport (GPU handshake, fill command,
//        fill status, BRAM write port)
//
// state | meaning
// IDLE  | no fill active; GPU always granted; accepts fill_start
// FILL  | fill engine running; port shared round-robin with the GPU
// DONE  | one-cycle fill_done pulse, then back to IDLE
module fbuf_fill_arbiter #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    fbuf_fill_arbiter_if.slave bus
);
    localparam int AW = FBUF_ADDR_WIDTH;
    localparam int DW = FBUF_DATA_WIDTH;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            last_fill;   // 1: the most recent grant went to the fill engine
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   len_q;
    logic [AW-1:0]   count;
    logic [DW-1:0]   color_q;

    logic            busy_q;
    logic            done_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;

    logic            ready;
    logic            gpu_grant;
    logic            fill_grant;
    logic [AW-1:0]   count_next;
    logic [AW-1:0]   fill_addr;

    // The GPU is only held off while filling, and only right after it was served.
    assign ready      = (state != FILL) || last_fill;
    assign gpu_grant  = bus.gpu_wr_valid && ready;
    assign fill_grant = (state == FILL) && !gpu_grant;
    assign count_next = count + ONE;
    assign fill_addr  = base_q + count;   // wraps at 2^AW by truncation

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_fill <= 1'b1;
            base_q    <= '0;
            len_q     <= '0;
            count     <= '0;
            color_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            wr_q <= gpu_grant || fill_grant;
            if (gpu_grant) begin
                addr_q    <= bus.gpu_wr_addr;
                data_q    <= bus.gpu_wr_data;
                last_fill <= 1'b0;
            end else if (fill_grant) begin
                addr_q    <= fill_addr;
                data_q    <= color_q;
                last_fill <= 1'b1;
                count     <= count_next;
            end

            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.fill_start) begin
                        if (bus.fill_len != '0) begin
                            base_q  <= bus.fill_base;
                            len_q   <= bus.fill_len;
                            color_q <= bus.fill_color;
                            count   <= '0;
                            state   <= FILL;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_grant && (count_next == len_q)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gpu_wr_ready = ready;
    assign bus.fill_busy    = busy_q;
    assign bus.fill_done    = done_q;
    assign bus.fbuf_en_wr   = wr_q;
    assign bus.fbuf_wrea    = wr_q;
    assign bus.fbuf_addr    = addr_q;
    assign bus.fbuf_data    = data_q;
endmodule

// File: tb/tb_fbuf_fill_arbiter.sv
module tb_fbuf_fill_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fbuf_fill_arbiter_if #(.FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW)) bus ();

    fbuf_fill_arbiter #(.FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a fill is "pixels remaining + next address"; the
    // round-robin is "whoever was served last yields if the other wants it".
    logic          m_last_fill;
    int            m_rem;
    logic          m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_color;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
    logic          exp_done;

    int obs_busy, obs_done, obs_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_last_fill = 1'b1;
        m_rem       = 0;
        m_done      = 1'b0;
        m_addr      = '0;
        m_color     = '0;
        exp_en      = 1'b0;
        exp_addr    = '0;
        exp_data    = '0;
        exp_busy    = 1'b0;
        exp_done    = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.gpu_wr_valid = 1'b0;
        bus.gpu_wr_addr  = '0;
        bus.gpu_wr_data  = '0;
        bus.fill_start   = 1'b0;
        bus.fill_base    = '0;
        bus.fill_len     = '0;
        bus.fill_color   = '0;
    endtask

    task automatic clear_counts();
        obs_busy = 0;
        obs_done = 0;
        obs_wr   = 0;
    endtask

    // One clock: predict from current inputs, check ready, clock, check outputs.
    task automatic cyc();
        logic ready, gg, fg, idle, done_next;
        #1;
        idle  = (m_rem == 0) && !m_done;
        ready = (m_rem == 0) || m_last_fill;
        chk("gpu_wr_ready", bus.gpu_wr_ready, ready);
        gg = bus.gpu_wr_valid && ready;
        fg = (m_rem > 0) && !gg;
        done_next = 1'b0;
        exp_en = gg || fg;
        if (gg) begin
            exp_addr    = bus.gpu_wr_addr;
            exp_data    = bus.gpu_wr_data;
            m_last_fill = 1'b0;
        end else if (fg) begin
            exp_addr    = m_addr;
            exp_data    = m_color;
            m_addr      = m_addr + 1'b1;
            m_rem       = m_rem - 1;
            m_last_fill = 1'b1;
            if (m_rem == 0) done_next = 1'b1;
        end
        if (idle && bus.fill_start) begin
            if (bus.fill_len != '0) begin
                m_rem   = int'(bus.fill_len);
                m_addr  = bus.fill_base;
                m_color = bus.fill_color;
            end else begin
                done_next = 1'b1;
            end
        end
        m_done   = done_next;
        exp_busy = (m_rem > 0);
        exp_done = m_done;

        @(posedge clk);
        #1;
        chk("fbuf_en_wr", bus.fbuf_en_wr, exp_en);
        chk("fbuf_wrea",  bus.fbuf_wrea,  exp_en);
        chk("fbuf_addr",  bus.fbuf_addr,  exp_addr);
        chk("fbuf_data",  bus.fbuf_data,  exp_data);
        chk("fill_busy",  bus.fill_busy,  exp_busy);
        chk("fill_done",  bus.fill_done,  exp_done);
        obs_busy += int'(bus.fill_busy);
        obs_done += int'(bus.fill_done);
        obs_wr   += int'(bus.fbuf_en_wr);
        bus.fill_start = 1'b0;
    endtask

    task automatic start_fill(input logic [AW-1:0] base, input logic [AW-1:0] len,
                              input logic [DW-1:0] color);
        bus.fill_start = 1'b1;
        bus.fill_base  = base;
        bus.fill_len   = len;
        bus.fill_color = color;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        clear_counts();
        #2;
        chk("rst_en",    bus.fbuf_en_wr,   0);
        chk("rst_wrea",  bus.fbuf_wrea,    0);
        chk("rst_addr",  bus.fbuf_addr,    0);
        chk("rst_data",  bus.fbuf_data,    0);
        chk("rst_busy",  bus.fill_busy,    0);
        chk("rst_done",  bus.fill_done,    0);
        chk("rst_ready", bus.gpu_wr_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Single GPU write in IDLE.
        bus.gpu_wr_valid = 1'b1;
        bus.gpu_wr_addr  = 19'h00001;
        bus.gpu_wr_data  = 8'hA5;
        cyc();
        chk("gpu_wr_addr_out", bus.fbuf_addr, 19'h00001);
        chk("gpu_wr_data_out", bus.fbuf_data, 8'hA5);
        chk("gpu_wr_en_out",   bus.fbuf_en_wr, 1);
        clear_inputs();
        cyc();

        // Uncontended fill.
        clear_counts();
        start_fill(19'h00100, 19'd4, 8'h3C);
        for (int i = 0; i < 7; i++) cyc();
        chk("fill4_busy_cycles", obs_busy, 4);
        chk("fill4_done_pulses", obs_done, 1);
        chk("fill4_writes",      obs_wr,   4);

        // Same fill with the GPU hammering the port from the first FILL cycle.
        clear_counts();
        start_fill(19'h00100, 19'd4, 8'h3C);
        cyc();
        bus.gpu_wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.gpu_wr_addr = AW'($urandom);
            bus.gpu_wr_data = DW'($urandom);
            cyc();
        end
        bus.gpu_wr_valid = 1'b0;
        cyc();
        chk("contend_busy_cycles", obs_busy, 8);
        chk("contend_done_pulses", obs_done, 1);

        // Wrapping fill, then a zero-length fill.
        start_fill(19'h7FFFE, 19'd3, 8'h5A);
        for (int i = 0; i < 6; i++) cyc();
        clear_counts();
        start_fill(19'h00040, 19'd0, 8'hFF);
        for (int i = 0; i < 4; i++) cyc();
        chk("len0_writes",      obs_wr,   0);
        chk("len0_done_pulses", obs_done, 1);
        chk("len0_busy_cycles", obs_busy, 0);

        // Re-pulsed fill_start mid-fill is ignored.
        clear_counts();
        start_fill(19'h00200, 19'd6, 8'h11);
        cyc();
        cyc();
        start_fill(19'h00300, 19'd6, 8'h99);
        for (int i = 0; i < 8; i++) cyc();
        chk("restart_writes",      obs_wr,   6);
        chk("restart_done_pulses", obs_done, 1);

        // Asynchronous reset in the middle of a fill.
        start_fill(19'h00400, 19'd10, 8'h77);
        for (int i = 0; i < 3; i++) cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_en",    bus.fbuf_en_wr,   0);
        chk("arst_wrea",  bus.fbuf_wrea,    0);
        chk("arst_busy",  bus.fill_busy,    0);
        chk("arst_done",  bus.fill_done,    0);
        chk("arst_ready", bus.gpu_wr_ready, 1);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 15; i++) cyc();
        chk("arst_no_done", obs_done, 0);
        chk("arst_no_wr",   obs_wr,   0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.gpu_wr_valid = ($urandom_range(0, 3) != 0);
            bus.gpu_wr_addr  = AW'($urandom);
            bus.gpu_wr_data  = DW'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    start_fill(19'h7FFFC + AW'($urandom_range(0, 3)),
                               AW'($urandom_range(0, 6)), DW'($urandom));
                else
                    start_fill(AW'($urandom), AW'($urandom_range(0, 6)), DW'($urandom));
            end
            cyc();
        end
        clear_inputs();
        for (int i = 0; i < 16; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
